// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: FSM state encoding, BCD digit limits and time-word width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // {minutes, seconds tens, seconds ones, tenths}
  function automatic int time_w(input int min_digits);
    return 12 + 4 * min_digits;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit rolling over at LIMIT, with clamped parallel load and ripple carry/borrow.
// Latency: q updates on the edge after inc/dec/ld; co/bo are combinational from inc/dec and q.
// Backpressure: none; a digit advances on every enabled cycle.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] LIMIT = BCD_MAX
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       co,
  output logic       bo
);

  assign co = inc && (q == LIMIT);
  assign bo = dec && (q == 4'd0);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 4'd0;
    end else if (ld) begin
      // out-of-range preset digits saturate rather than wrap
      q <= (ld_val > LIMIT) ? LIMIT : ld_val;
    end else if (inc) begin
      q <= co ? 4'd0 : q + 4'd1;
    end else if (dec) begin
      q <= bo ? LIMIT : q - 4'd1;
    end
  end

endmodule

// File: rtl/lap_timer.sv
// BCD stopwatch (up/down, tenth-second resolution) with a first-word fall-through lap-capture FIFO.
// Latency: a tick or control pulse in cycle N is visible on every output in cycle N+1.
// Backpressure: none upstream; laps pushed while the FIFO is full are dropped and flagged on lap_ovf.
module lap_timer
  import stopwatch_pkg::*;
#(
  parameter int MIN_DIGITS = 1,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      en,
  input  logic                      start_stop,
  input  logic                      lap,
  input  logic                      dir,
  input  logic                      load,
  input  logic [12+4*MIN_DIGITS-1:0] preset,
  input  logic                      lap_rd,
  output logic [3:0]                q0,
  output logic [7:0]                qs,
  output logic [4*MIN_DIGITS-1:0]   qm,
  output logic [12+4*MIN_DIGITS-1:0] lap_data,
  output logic                      lap_valid,
  output logic                      lap_full,
  output logic                      lap_ovf,
  output logic                      running,
  output logic                      done,
  output logic                      wrap
);

  localparam int TW   = time_w(MIN_DIGITS);
  localparam int NDIG = 3 + MIN_DIGITS;
  localparam int AW   = $clog2(LAP_DEPTH);

  state_t          state, state_nxt;
  logic            dir_q;
  logic [TW-1:0]   cnt;
  logic            load_eff, tick, tick_up, tick_dn;
  logic            cnt_is_zero, cnt_is_one;
  logic [NDIG-1:0] dinc, ddec, dco, dbo;
  logic            top_borrow_unused;

  assign load_eff    = load && (state != RUN);
  assign tick        = en && (state == RUN);
  assign tick_up     = tick && !dir_q;
  assign tick_dn     = tick && dir_q;
  assign cnt_is_zero = (cnt == '0);
  assign cnt_is_one  = (cnt == TW'(1));

  // tenths, seconds ones, seconds tens (limit 5), then minute digits
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign dinc[i] = tick_up;
      assign ddec[i] = tick_dn;
    end else begin : g_chain
      assign dinc[i] = dco[i-1];
      assign ddec[i] = dbo[i-1];
    end

    bcd_digit #(
      .LIMIT((i == 2) ? SEC_TENS_MAX : BCD_MAX)
    ) u_dig (
      .clk    (clk),
      .clr    (clr),
      .ld     (load_eff),
      .ld_val (preset[4*i +: 4]),
      .inc    (dinc[i]),
      .dec    (ddec[i]),
      .q      (cnt[4*i +: 4]),
      .co     (dco[i]),
      .bo     (dbo[i])
    );
  end

  // a down-count never borrows past zero: it stops in DONE first
  assign top_borrow_unused = dbo[NDIG-1];

  assign q0 = cnt[3:0];
  assign qs = cnt[11:4];
  assign qm = cnt[TW-1:12];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load) state_nxt = IDLE;
        else if (start_stop) state_nxt = (dir_q && cnt_is_zero) ? DONE : RUN;
      end
      RUN: begin
        // reaching zero wins over a coincident pause so the count never restarts at zero
        if (tick_dn && cnt_is_one) state_nxt = DONE;
        else if (start_stop) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (load) state_nxt = IDLE;
        else if (start_stop) state_nxt = RUN;
      end
      DONE: begin
        if (load) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      dir_q   <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
      done    <= (state_nxt == DONE);
      wrap    <= tick_up && dco[NDIG-1];
      if (load_eff) dir_q <= dir;
    end
  end

  // lap FIFO: power-of-two ring, pointers wrap naturally
  logic [TW-1:0] mem [LAP_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   lcnt;
  logic          push, pop, push_ok;

  assign lap_valid = (lcnt != '0);
  assign lap_full  = (lcnt == (AW+1)'(LAP_DEPTH));
  assign lap_data  = mem[rptr];
  assign push      = lap && ((state == RUN) || (state == PAUSE));
  assign pop       = lap_rd && lap_valid;
  assign push_ok   = push && (!lap_full || pop);

  always_ff @(posedge clk) begin
    if (clr || load_eff) begin
      wptr    <= '0;
      rptr    <= '0;
      lcnt    <= '0;
      lap_ovf <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   lcnt <= lcnt + (AW+1)'(1);
        2'b01:   lcnt <= lcnt - (AW+1)'(1);
        default: lcnt <= lcnt;
      endcase
      if (push && !push_ok) lap_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= cnt;
  end

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 SHALL have parameter MIN_DIGITS, default 1, meaning number of BCD minute digits (1..3).
REQ-002 SHALL have parameter LAP_DEPTH, default 4, meaning lap-capture FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port clr  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port en  input  1  tenth-second tick, one-cycle pulse.
REQ-006 SHALL have port start_stop  input  1  one-cycle pulse toggling run/pause.
REQ-007 SHALL have port lap  input  1  one-cycle pulse capturing the current time.
REQ-008 SHALL have port dir  input  1  0 = count up, 1 = count down; sampled only on load.
REQ-009 SHALL have port load  input  1  one-cycle pulse loading preset and dir.
REQ-010 SHALL have port preset  input  12+4*MIN_DIGITS  {minutes, seconds[7:0], tenths[3:0]}, BCD.
REQ-011 SHALL have port lap_rd  input  1  pops the FIFO head.
REQ-012 SHALL have port q0 / qs / qm  output  4 / 8 / 4*MIN_DIGITS  live tenths / seconds / minutes, BCD.
REQ-013 SHALL have port lap_data  output  12+4*MIN_DIGITS  FIFO head, same packing as preset.
REQ-014 SHALL have port lap_valid / lap_full / lap_ovf  output  1 each  FIFO non-empty / full / sticky drop flag.
REQ-015 SHALL have port running / done / wrap  output  1 each  RUN state / DONE state / one-cycle up-count rollover pulse.

Function
REQ-016 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-017 Transitions SHALL be: IDLE/PAUSE -start_stop-> RUN; RUN -start_stop-> PAUSE; RUN, dir=1, count reaches 0.00.0 -> DONE; load in IDLE/PAUSE/DONE -> IDLE.
REQ-018 load in RUN SHALL be ignored.
REQ-019 In IDLE, start_stop with a count of 0.00.0 and dir=1 SHALL go directly to DONE.
REQ-020 In RUN, each en pulse SHALL advance the count by one tenth.
REQ-021 en outside RUN SHALL be ignored.
REQ-022 Outputs SHALL be registered; a tick in cycle N SHALL be visible in cycle N+1.
REQ-023 Up-count rollover SHALL be: tenths 9->0 carries seconds; seconds 59->00 carries minutes; minutes 10^MIN_DIGITS-1 -> 0 wraps the whole count to zero and pulses wrap for one cycle.
REQ-024 Down-count SHALL borrow symmetrically: tenths 0->9; seconds 00->59.
REQ-025 The tick producing 0.00.0 SHALL enter DONE in the same edge; done SHALL stay high and the count SHALL hold until load or clr.
REQ-026 A preset with an invalid BCD field (digit >9, or seconds tens >5) SHALL be clamped per field to its maximum legal value.
REQ-027 lap in RUN or PAUSE SHALL push the pre-tick count of that cycle.
REQ-028 lap in IDLE or DONE SHALL be ignored.
REQ-029 When start_stop and lap coincide, the capture SHALL occur and the state SHALL change.
REQ-030 A push while full SHALL be dropped and set lap_ovf; lap_ovf SHALL clear only on clr or load.
REQ-031 Simultaneous push and pop while full SHALL both succeed, with no drop.
REQ-032 lap_rd while empty SHALL be ignored.
REQ-033 lap_data SHALL be valid whenever lap_valid=1 (first-word fall-through).
REQ-034 load SHALL flush the FIFO.

Reset
REQ-035 clr SHALL force: state IDLE, q0=0, qs=8'h00, qm=0, dir=0, FIFO empty, lap_valid=0, lap_full=0, lap_ovf=0, running=0, done=0, wrap=0.
REQ-036 clr SHALL override every other input in the same cycle, including mid-count and mid-FIFO-access.

Structure
REQ-037 Package stopwatch_pkg SHALL hold the state enum, BCD limit constants (9, 5) and the time-word width function of MIN_DIGITS.
REQ-038 A single sub-module bcd_digit SHALL be used per digit, with a LIMIT parameter, inc/dec enable, carry/borrow out and load; the digit chain SHALL be instantiated by generate.
REQ-039 The FIFO SHALL be inline (pointer plus count), not a separate module.

Verification
REQ-040 Verify: clr; start_stop; 600 en pulses -> qm=1, qs=8'h00, q0=0, running=1.
REQ-041 Verify: MIN_DIGITS=1, load preset 9.59.9 with dir=0; start; 1 en -> count 0.00.0, wrap high exactly one cycle.
REQ-042 Verify: load 0.01.5 with dir=1; start; 15 en -> done=1, running=0, count 0.00.0; a further 5 en -> count unchanged.
REQ-043 Verify: LAP_DEPTH=4; 5 lap pulses during RUN at distinct counts -> lap_full=1, lap_ovf=1, pops return the first 4 counts in order, then lap_valid=0.
REQ-044 Verify: lap and en in the same cycle at 0.12.3 -> captured entry is 0.12.3, live count becomes 0.12.4.
REQ-045 Verify: clr asserted mid-RUN at count 3.45.6 with 2 entries queued -> next cycle all outputs at reset values.
